// File: rtl/conv3x3_engine_if.sv
// Column-in / pixel-out bus of the 3x3 convolution engine.
// coef packs k[0..8] with k[0] (top-left) in the least significant COEF_W bits.
interface conv3x3_engine_if #(
  parameter int WIDTH  = 8,
  parameter int COEF_W = 8
);
  logic                  in_en;
  logic                  in_ready;
  logic [WIDTH-1:0]      din_r0;
  logic [WIDTH-1:0]      din_r1;
  logic [WIDTH-1:0]      din_r2;
  logic [3:0]            corner_type;
  logic [9*COEF_W-1:0]   coef;
  logic [WIDTH-1:0]      dout;
  logic                  dout_valid;
  logic                  dout_eol;
  logic                  dout_eof;

  modport master (
    output in_en, din_r0, din_r1, din_r2, corner_type, coef,
    input  in_ready, dout, dout_valid, dout_eol, dout_eof
  );

  modport slave (
    input  in_en, din_r0, din_r1, din_r2, corner_type, coef,
    output in_ready, dout, dout_valid, dout_eol, dout_eof
  );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 signed convolution on tagged pixel columns with tag-driven zero padding; EMIT to dout_valid is 3 cycles.
// in_ready drops for the single FLUSH cycle after each row-end column; a column offered then is dropped.
module conv3x3_engine #(
  parameter int WIDTH   = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT   = 0,
  parameter int COL_NUM = 8
) (
  input  logic            clk,
  input  logic            rst,
  conv3x3_engine_if.slave bus,
  output logic            err_overrun
);
  localparam int PROD_W  = WIDTH + COEF_W + 1;
  localparam int SUM_W   = PROD_W + 4;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int RND_I   = (SHIFT > 0) ? (1 << RND_POS) : 0;
  localparam int CNT_W   = $clog2(COL_NUM + 1);
  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(RND_I);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << WIDTH) - 1);

  typedef struct packed {
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
  } col_t;

  typedef struct packed {
    logic eol;
    logic eof;
  } meta_t;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                   state;
  logic                     rdy;
  logic                     pend;
  col_t                     col_l;
  col_t                     col_c;
  logic [3:0]               tag_c;
  logic signed [COEF_W-1:0] coef_r [9];

  col_t                     col_n;
  col_t                     col_r;
  logic                     tag_ok;
  logic                     take;
  logic                     emit;
  logic                     m_left, m_right, m_top, m_bot;
  logic [WIDTH-1:0]         win [9];
  meta_t                    meta_n;
  logic signed [COEF_W-1:0] coef_n [9];
  logic signed [PROD_W-1:0] prod_n [9];

  logic                     s1_vld;
  meta_t                    s1_meta;
  logic signed [PROD_W-1:0] prod_q [9];
  logic                     s2_vld;
  meta_t                    s2_meta;
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  sum_n, rnd_n, shr_n;
  logic [WIDTH-1:0]         sat_n;

  logic [WIDTH-1:0]         dout_r;
  logic                     vld_r, eol_r, eof_r;
  logic [CNT_W-1:0]         row_cnt;

  assign bus.in_ready   = rdy;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = vld_r;
  assign bus.dout_eol   = eol_r;
  assign bus.dout_eof   = eof_r;

  // S0: window assembly; in FLUSH the right column is the zero pad past the row end.
  always_comb begin
    col_n   = {bus.din_r0, bus.din_r1, bus.din_r2};
    tag_ok  = (bus.corner_type >= 4'd1) && (bus.corner_type <= 4'd8);
    take    = bus.in_en && rdy && tag_ok;
    emit    = (state == FLUSH) || (take && pend);
    col_r   = (state == FLUSH) ? '0 : col_n;
    m_left  = !(tag_c inside {4'd1, 4'd3, 4'd5});
    m_right = !(tag_c inside {4'd2, 4'd4, 4'd6});
    m_top   = !(tag_c inside {4'd1, 4'd2});
    m_bot   = !(tag_c inside {4'd5, 4'd6, 4'd7});

    win[0] = (m_top && m_left)  ? col_l.r2 : '0;
    win[1] = m_top              ? col_c.r2 : '0;
    win[2] = (m_top && m_right) ? col_r.r2 : '0;
    win[3] = m_left             ? col_l.r1 : '0;
    win[4] = col_c.r1;
    win[5] = m_right            ? col_r.r1 : '0;
    win[6] = (m_bot && m_left)  ? col_l.r0 : '0;
    win[7] = m_bot              ? col_c.r0 : '0;
    win[8] = (m_bot && m_right) ? col_r.r0 : '0;

    meta_n     = '0;
    meta_n.eol = tag_c inside {4'd2, 4'd4, 4'd6};
    meta_n.eof = (tag_c == 4'd6);

    for (int i = 0; i < 9; i++) begin
      coef_n[i] = bus.coef[i*COEF_W +: COEF_W];
      prod_n[i] = PROD_W'(signed'({1'b0, win[i]})) * PROD_W'(coef_r[i]);
    end
  end

  always_comb begin
    sum_n = '0;
    for (int i = 0; i < 9; i++) begin
      sum_n = sum_n + SUM_W'(prod_q[i]);
    end
    rnd_n = sum_q + RND;
    shr_n = rnd_n >>> SHIFT;
    if (shr_n[SUM_W-1]) begin
      sat_n = '0;
    end else if (shr_n > SAT_MAX) begin
      sat_n = '1;
    end else begin
      sat_n = shr_n[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      rdy         <= 1'b1;
      pend        <= 1'b0;
      col_l       <= '0;
      col_c       <= '0;
      tag_c       <= '0;
      err_overrun <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        coef_r[i] <= '0;
      end
    end else begin
      case (state)
        RUN: begin
          if (take) begin
            col_l <= col_c;
            col_c <= col_n;
            tag_c <= bus.corner_type;
            pend  <= 1'b1;
            if (bus.corner_type == 4'd1) begin
              coef_r <= coef_n;
            end
            if (bus.corner_type inside {4'd2, 4'd4, 4'd6}) begin
              state <= FLUSH;
              rdy   <= 1'b0;
            end
          end
        end
        FLUSH: begin
          pend  <= 1'b0;
          state <= RUN;
          rdy   <= 1'b1;
        end
      endcase
      if (bus.in_en && (!rdy || !tag_ok)) begin
        err_overrun <= 1'b1;
      end
    end
  end

  // S1 products, S2 sum, S3 round/saturate into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_meta <= '0;
      s2_vld  <= 1'b0;
      s2_meta <= '0;
      sum_q   <= '0;
      dout_r  <= '0;
      vld_r   <= 1'b0;
      eol_r   <= 1'b0;
      eof_r   <= 1'b0;
      row_cnt <= '0;
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      s1_vld  <= emit;
      s1_meta <= meta_n;
      prod_q  <= prod_n;
      s2_vld  <= s1_vld;
      s2_meta <= s1_meta;
      sum_q   <= sum_n;
      vld_r   <= s2_vld;
      eol_r   <= s2_vld && s2_meta.eol;
      eof_r   <= s2_vld && s2_meta.eof;
      if (s2_vld) begin
        dout_r  <= sat_n;
        row_cnt <= s2_meta.eol ? '0 : row_cnt + 1'b1;
        if (s2_meta.eol) begin
          assert (row_cnt == CNT_W'(COL_NUM - 1));
        end
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench: two engines (SHIFT 0 and 3) see identical column streams; a direct 3x3 image model
// predicts every pixel at issue time and a negedge monitor pops and compares.
module tb_conv3x3_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err0, err1;

  conv3x3_engine_if #(.WIDTH(8), .COEF_W(8)) bus0 ();
  conv3x3_engine_if #(.WIDTH(8), .COEF_W(8)) bus1 ();

  conv3x3_engine #(.WIDTH(8), .COEF_W(8), .SHIFT(0), .COL_NUM(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .err_overrun(err0)
  );
  conv3x3_engine #(.WIDTH(8), .COEF_W(8), .SHIFT(3), .COL_NUM(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .err_overrun(err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    bit         eol;
    bit         eof;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lat_due = -1;
  int   last0 = 0;
  int   img [5][8];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pv(input int x, input int y);
    if (x < 0 || x > 7 || y < 0 || y > 4) return 0;
    return img[y][x];
  endfunction

  function automatic int model(input int x, input int y, input logic [71:0] k, input int sh);
    int s;
    logic signed [7:0] kk;
    s = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        kk = k[((dy + 1) * 3 + dx + 1) * 8 +: 8];
        s += int'(kk) * pv(x + dx, y + dy);
      end
    end
    if (sh > 0) s += 1 << (sh - 1);
    s = s >>> sh;
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
    return s;
  endfunction

  function automatic logic [71:0] kern(input int center, input int others);
    logic [71:0] k;
    logic [7:0]  c8, o8;
    c8 = center[7:0];
    o8 = others[7:0];
    for (int i = 0; i < 9; i++) k[i*8 +: 8] = (i == 4) ? c8 : o8;
    return k;
  endfunction

  function automatic logic [3:0] tag_of(input int x, input int y);
    if (y == 0) return (x == 0) ? 4'd1 : (x == 7) ? 4'd2 : 4'd8;
    if (y == 4) return (x == 0) ? 4'd5 : (x == 7) ? 4'd6 : 4'd7;
    return (x == 0) ? 4'd3 : (x == 7) ? 4'd4 : 4'd8;
  endfunction

  task automatic set_img(input int mode);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 8; x++)
        img[y][x] = (mode == 0) ? x + 8 * y : mode;
  endtask

  task automatic set_coef(input logic [71:0] k);
    bus0.coef = k;
    bus1.coef = k;
  endtask

  task automatic idle();
    bus0.in_en = 1'b0;
    bus1.in_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_col(input int r0, input int r1, input int r2, input logic [3:0] tag,
                          input int exp_rdy, output int c);
    bus0.in_en = 1'b1;       bus1.in_en = 1'b1;
    bus0.din_r0 = r0[7:0];   bus1.din_r0 = r0[7:0];
    bus0.din_r1 = r1[7:0];   bus1.din_r1 = r1[7:0];
    bus0.din_r2 = r2[7:0];   bus1.din_r2 = r2[7:0];
    bus0.corner_type = tag;  bus1.corner_type = tag;
    @(negedge clk);
    check("in_ready", bus0.in_ready, exp_rdy);
    @(posedge clk);
    #1;
    c = cyc;
  endtask

  // Full 8x5 frame under kernel kf; kmid is driven mid-frame and must be ignored.
  task automatic send_frame(input logic [71:0] kf, input logic [71:0] kmid, input bit viol,
                            input bit probe, input int stop_after);
    int c;
    exp_t e;
    set_coef(kf);
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (stop_after >= 0 && y * 8 + x == stop_after) return;
        if (y == 2 && x == 3) set_coef(kmid);
        e.eol = (x == 7);
        e.eof = (x == 7 && y == 4);
        e.pix = 8'(model(x, y, kf, 0));
        q0.push_back(e);
        e.pix = 8'(model(x, y, kf, 3));
        q1.push_back(e);
        send_col((y == 4) ? 32'hA5 : pv(x, y + 1), pv(x, y), pv(x, y - 1), tag_of(x, y), 1, c);
        if (probe && y == 0 && x == 1) lat_due = c + 2;
        if (x == 7) begin
          if (viol && y == 1) send_col(8'h33, 8'h33, 8'h33, 4'd8, 0, c);
          else idle();
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.dout_valid) begin
        if (lat_due >= 0) begin
          check("latency_cycle", cyc, lat_due);
          lat_due = -1;
        end
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dut0_unexpected: got pixel %0d expected none", bus0.dout);
        end else begin
          e0 = q0.pop_front();
          check("dut0_pix", bus0.dout, e0.pix);
          check("dut0_eol_eof", {bus0.dout_eol, bus0.dout_eof}, {e0.eol, e0.eof});
          last0 = e0.pix;
        end
      end
      if (bus1.dout_valid) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dut1_unexpected: got pixel %0d expected none", bus1.dout);
        end else begin
          e1 = q1.pop_front();
          check("dut1_pix", bus1.dout, e1.pix);
          check("dut1_eol_eof", {bus1.dout_eol, bus1.dout_eof}, {e1.eol, e1.eof});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [71:0] kid, kbox;
    int c;
    kid  = kern(1, 0);
    kbox = kern(1, 1);
    bus0.in_en = 1'b0;  bus1.in_en = 1'b0;
    bus0.din_r0 = '0;   bus1.din_r0 = '0;
    bus0.din_r1 = '0;   bus1.din_r1 = '0;
    bus0.din_r2 = '0;   bus1.din_r2 = '0;
    bus0.corner_type = '0;
    bus1.corner_type = '0;
    set_coef('0);
    set_img(0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout_valid", bus0.dout_valid, 0);
    check("rst_in_ready", bus0.in_ready, 1);
    check("rst_err", err0, 0);
    check("rst_dout", bus0.dout, 0);
    check("rst_eol_eof", {bus0.dout_eol, bus0.dout_eof}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // identity on the ramp, first-pixel latency probed
    set_img(0);
    send_frame(kid, kid, 0, 1, -1);
    check("err_after_identity", err0, 0);

    // box kernel on constant 10: 40/60/90 at SHIFT 0, 5/8/11 at SHIFT 3
    set_img(10);
    send_frame(kbox, kbox, 0, 0, -1);

    // saturation high and low on constant 200
    set_img(200);
    send_frame(kern(2, 0), kern(2, 0), 0, 0, -1);
    send_frame(kern(-1, 0), kern(-1, 0), 0, 0, -1);
    check("err_proper_gaps_dut0", err0, 0);
    check("err_proper_gaps_dut1", err1, 0);

    // column offered during FLUSH is dropped and flagged
    set_img(0);
    send_frame(kid, kid, 1, 0, -1);
    check("err_flush_drop_dut0", err0, 1);
    check("err_flush_drop_dut1", err1, 1);

    // reset in the middle of row 1
    send_frame(kid, kid, 0, 0, 12);
    rst = 1'b1;
    bus0.in_en = 1'b0;
    bus1.in_en = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_dout_valid", bus0.dout_valid, 0);
    check("midrst_in_ready", bus0.in_ready, 1);
    check("midrst_err", err0, 0);
    @(posedge clk);
    #1;
    send_frame(kid, kid, 0, 0, -1);
    check("err_after_rst_frame", err0, 0);

    // illegal tag: dropped, flagged, stream unaffected
    send_col(7, 7, 7, 4'd0, 1, c);
    idle();
    check("err_illegal_tag", err0, 1);

    // back-to-back frames; box driven mid-frame only takes effect at frame 2 start
    send_frame(kid, kbox, 0, 0, -1);
    send_frame(kbox, kbox, 0, 0, -1);

    repeat (6) idle();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    @(negedge clk);
    check("idle_dout_valid", bus0.dout_valid, 0);
    check("dout_hold", bus0.dout, last0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
